// File: rtl/word_receiver_if.sv
// Serial-in / word-out bus of the word receiver: bit stream and control from
// the sampler side, held word with valid/ready toward the consumer.
interface word_receiver_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 6
);
  logic             enable;
  logic             in;
  logic             flush;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic [CW-1:0]    bit_count;
  logic             overflow;

  // master: bit source / consumer side; slave: the receiver itself
  modport master (
    output enable, in, flush, out_ready,
    input  out, out_valid, bit_count, overflow
  );

  modport slave (
    input  enable, in, flush, out_ready,
    output out, out_valid, bit_count, overflow
  );
endinterface

// File: rtl/word_receiver.sv
// Serial-to-parallel receiver: shifts bits MSB first, presents each completed
// word on a held output register with valid/ready, and flags dropped words.
module word_receiver #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 6
) (
  input  logic            clk,
  input  logic            reset,
  word_receiver_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] out_q, out_d;
  out_state_t       state_q, state_d;
  logic             ovf_q, ovf_d;

  logic             last_bit_c;
  logic             complete_c;
  logic [WIDTH-1:0] word_c;

  // The completing bit is folded in directly so words leave with no dead cycle.
  assign last_bit_c = (count_q == CW'(WIDTH - 1));
  assign complete_c = bus.enable & ~bus.flush & last_bit_c;
  assign word_c     = {shift_q[WIDTH-2:0], bus.in};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      count_q <= '0;
      out_q   <= '0;
      state_q <= EMPTY;
      ovf_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
      out_q   <= out_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    out_d   = out_q;
    state_d = state_q;
    ovf_d   = ovf_q;

    // Shift side: flush beats enable and also clears the sticky overflow.
    if (bus.flush) begin
      shift_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (bus.enable) begin
      shift_d = word_c;
      count_d = last_bit_c ? '0 : count_q + CW'(1);
    end

    // Output side: a word completing into a full, unread register is lost.
    if (complete_c) begin
      if (state_q == EMPTY) begin
        out_d   = word_c;
        state_d = FULL;
      end else if (bus.out_ready) begin
        out_d   = word_c;
      end else begin
        ovf_d   = 1'b1;
      end
    end else if ((state_q == FULL) && bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = (state_q == FULL);
  assign bus.bit_count = count_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_word_receiver.sv
// Bench for word_receiver: table of single-word vectors plus hand-written
// back-to-back, overflow, flush and asynchronous-reset sequences.
module tb_word_receiver;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CW    = 6;

  logic clk;
  logic reset;

  word_receiver_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  word_receiver #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors;
  int unsigned checks;
  int unsigned exp_cnt;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] word;
    bit          gaps;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic ready);
    bus.enable    = 1'b0;
    bus.out_ready = ready;
    step();
    bus.out_ready = 1'b0;
  endtask

  // Pop the expected word and compare it with the presented output.
  task automatic pop_check(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got 0x%08h expected <empty scoreboard>", name, bus.out);
    end else begin
      e = exp_q.pop_front();
      chk(name, 32'(bus.out), e);
      chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    end
  endtask

  task automatic shift_word(input logic [31:0] w, input bit gaps, input bit ready_last,
                            input bit hold_valid);
    int n;
    for (int i = 31; i >= 0; i--) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        n = int'($urandom_range(1, 3));
        repeat (n) begin
          idle_cycle(1'b0);
          chk("gap_count", 32'(bus.bit_count), exp_cnt);
        end
      end
      bus.enable    = 1'b1;
      bus.in        = w[i];
      bus.out_ready = ready_last && (i == 0);
      step();
      bus.enable    = 1'b0;
      bus.out_ready = 1'b0;
      exp_cnt = (exp_cnt == WIDTH - 1) ? 0 : exp_cnt + 1;
      chk("bit_count", 32'(bus.bit_count), exp_cnt);
      if (hold_valid) chk("valid_hold", 32'(bus.out_valid), 32'd1);
      else if (i != 0) chk("valid_early", 32'(bus.out_valid), 32'd0);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    exp_cnt = 0;
    reset   = 1'b0;
    bus.enable    = 1'b0;
    bus.in        = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0] = '{word: 32'hDEADBEEF, gaps: 1'b0, exp_out: 32'hDEADBEEF};
    vecs[1] = '{word: 32'h12345678, gaps: 1'b1, exp_out: 32'h12345678};
    vecs[2] = '{word: 32'h80000001, gaps: 1'b0, exp_out: 32'h80000001};
    vecs[3] = '{word: 32'hFFFFFFFF, gaps: 1'b1, exp_out: 32'hFFFFFFFF};
    vecs[4] = '{word: 32'h00000000, gaps: 1'b0, exp_out: 32'h00000000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out",   32'(bus.out),       32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(bus.bit_count), 32'd0);
    chk("rst_ovf",   32'(bus.overflow),  32'd0);
    reset = 1'b1;

    // Single words, consumed by a one-cycle ready pulse
    for (int v = 0; v < 5; v++) begin
      exp_q.push_back(vecs[v].word);
      shift_word(vecs[v].word, vecs[v].gaps, 1'b0, 1'b0);
      pop_check("vec_out");
      chk("vec_count", 32'(bus.bit_count), 32'd0);
      chk("vec_ovf",   32'(bus.overflow),  32'd0);
      idle_cycle(1'b1);
      chk("vec_consumed", 32'(bus.out_valid), 32'd0);
      chk("vec_held",     32'(bus.out),       vecs[v].exp_out);
    end

    // Back-to-back words, consumer takes word 1 as word 2 completes
    exp_q.push_back(32'hA5A5A5A5);
    shift_word(32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
    pop_check("b2b_first");
    exp_q.push_back(32'h0F0F0F0F);
    shift_word(32'h0F0F0F0F, 1'b0, 1'b1, 1'b1);
    pop_check("b2b_second");
    chk("b2b_ovf", 32'(bus.overflow), 32'd0);
    idle_cycle(1'b1);
    chk("b2b_consumed", 32'(bus.out_valid), 32'd0);

    // Back-to-back words with no consumer: second word dropped
    exp_q.push_back(32'hA5A5A5A5);
    shift_word(32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
    pop_check("drop_first");
    shift_word(32'h0F0F0F0F, 1'b0, 1'b0, 1'b1);
    chk("drop_out", 32'(bus.out),      32'hA5A5A5A5);
    chk("drop_ovf", 32'(bus.overflow), 32'd1);
    idle_cycle(1'b0);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_ovf",   32'(bus.overflow),  32'd0);
    chk("flush_valid", 32'(bus.out_valid), 32'd1);
    chk("flush_out",   32'(bus.out),       32'hA5A5A5A5);
    idle_cycle(1'b1);
    chk("drop_consumed", 32'(bus.out_valid), 32'd0);

    // Flush mid-word with enable high: no stale ones leak into the next word
    for (int i = 0; i < 10; i++) begin
      bus.enable = 1'b1;
      bus.in     = 1'b1;
      step();
    end
    exp_cnt = 10;
    chk("pre_flush_count", 32'(bus.bit_count), 32'd10);
    bus.flush = 1'b1;
    step();
    bus.flush  = 1'b0;
    bus.enable = 1'b0;
    exp_cnt = 0;
    chk("post_flush_count", 32'(bus.bit_count), 32'd0);
    chk("post_flush_valid", 32'(bus.out_valid), 32'd0);
    exp_q.push_back(32'h00000001);
    shift_word(32'h00000001, 1'b0, 1'b0, 1'b0);
    pop_check("flush_word");
    idle_cycle(1'b1);

    // Asynchronous reset between edges, mid-word, with a word held
    exp_q.push_back(32'h5555AAAA);
    shift_word(32'h5555AAAA, 1'b0, 1'b0, 1'b0);
    pop_check("pre_reset_word");
    for (int i = 0; i < 17; i++) begin
      bus.enable = 1'b1;
      bus.in     = 1'(i % 2);
      step();
    end
    bus.enable = 1'b0;
    chk("pre_reset_count", 32'(bus.bit_count), 32'd17);
    #2 reset = 1'b0;
    #1;
    chk("arst_out",   32'(bus.out),       32'd0);
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_count", 32'(bus.bit_count), 32'd0);
    chk("arst_ovf",   32'(bus.overflow),  32'd0);
    #3 reset = 1'b1;
    exp_cnt = 0;
    exp_q.push_back(32'hCAFEF00D);
    shift_word(32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
    pop_check("post_reset_word");
    chk("post_reset_ovf", 32'(bus.overflow), 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/word_receiver.md
Name: word_receiver

Overview:
- Serial-to-parallel receiver: the receive-side counterpart of the 32-bit serial word transmitter on the JTAG data path.
- Captures one bit per clock while enable is high, MSB first.
- Assembles WIDTH bits into a word and presents it on a held output register with a valid/ready handshake.
- Sits between the TDI sampling logic and the data-register consumer. Flags words lost because the consumer did not take the previous word.

Parameters:
- WIDTH, 32, bits per word; legal range 2..32.
- CW, 6, bit-counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; asserted at 0.
- enable  in  1  sample the in port this cycle.
- in  in  1  serial data bit.
- flush  in  1  discard the partial word and clear overflow.
- out_ready  in  1  consumer accepts out this cycle.
- out  out  WIDTH  last completed word.
- out_valid  out  1  out holds an unconsumed word.
- bit_count  out  CW  bits accepted into the current partial word, 0..WIDTH-1.
- overflow  out  1  sticky; a completed word was dropped.

Behaviour:
- Reset (asynchronous, reset=0):
  - shift register = 0; bit_count = 0; out = 0; out_valid = 0; overflow = 0.
  - Takes effect immediately, including mid-word; the partial word is lost.
  - Normal operation resumes on the first rising edge after reset returns to 1.
- Shift side, two states:
  - IDLE: bit_count == 0.
  - SHIFTING: bit_count 1..WIDTH-1.
- On each edge with enable=1 and flush=0:
  - shift register <= {shift register[WIDTH-2:0], in}, so the first received bit ends up in the MSB.
  - If bit_count < WIDTH-1: bit_count increments.
  - If bit_count == WIDTH-1: this is the completing bit, and bit_count <= 0 on the same edge.
- Completing bit:
  - The completed word is {shift register[WIDTH-2:0], in}; it is not taken from the shift register one cycle later.
  - No dead cycle between words. Back-to-back words need WIDTH consecutive enable cycles each.
- enable=0: shift register and bit_count hold. Gaps of any length between bits are legal.
- flush=1:
  - shift register <= 0, bit_count <= 0, overflow <= 0.
  - Any bit presented the same cycle is discarded; flush beats enable.
  - out and out_valid are unaffected.
- Output register, two states, EMPTY (out_valid=0) and FULL (out_valid=1). Decision per edge:
  - Completion while EMPTY: out <= word, out_valid <= 1. out_valid is visible the cycle after the completing bit (latency 1).
  - out_valid & out_ready with no completion: out_valid <= 0. out holds its old value; it is not cleared.
  - Completion while FULL with out_ready=1 the same cycle: out <= new word, out_valid stays 1, no overflow.
  - Completion while FULL with out_ready=0: new word dropped, out unchanged, overflow <= 1.
  - Completion coinciding with flush: flush wins, no completion and no overflow.
- out_ready while EMPTY has no effect.
- overflow stays high until reset or flush.
- bit_count never reaches WIDTH and wraps WIDTH-1 -> 0 only on the completing bit.
- All counter arithmetic is unsigned, CW bits.

Test Plan:
- Shift 0xDEADBEEF MSB first over 32 consecutive enable cycles, out_ready=0 -> out=0xDEADBEEF, out_valid=1 from the cycle after bit 32, bit_count=0, overflow=0. Then pulse out_ready for 1 cycle -> out_valid=0, out still 0xDEADBEEF.
- Shift 0x12345678 with enable toggling every other cycle (random gaps) -> identical result; bit_count stalls during gaps.
- Two back-to-back words 0xA5A5A5A5 then 0x0F0F0F0F, 64 consecutive enables, out_ready=1 on the completion cycle of word 2 -> out_valid never drops after the first completion, out ends at 0x0F0F0F0F, overflow=0.
- Same two words with out_ready=0 throughout -> out=0xA5A5A5A5, overflow=1 the cycle after bit 64. Then flush -> overflow=0, out_valid still 1.
- 10 bits of all ones, then flush with enable=1, then 0x00000001 -> bit_count=0 after flush, out=0x00000001, no ones leak in.
- Assert reset (0) asynchronously between edges after 17 bits with out_valid=1 -> all outputs 0 immediately. Release, shift 0xCAFEF00D -> out=0xCAFEF00D.
